// File: rtl/sha3_pad_absorb_buffer_if.sv
// Handshake bundle of the SHA-3 pad/absorb buffer: byte-stream input side and rate-block output side.
// The slave modport is the buffer itself; master is whatever feeds bytes and consumes blocks.
interface sha3_pad_absorb_buffer_if #(
    parameter int R_BLOCK_SIZE = 1152
);
    logic [7:0]              IN_BYTE;
    logic                    IN_VALID;
    logic                    IN_KEEP;
    logic                    IN_LAST;
    logic                    IN_READY;
    logic [R_BLOCK_SIZE-1:0] BLOCK_OUT;
    logic                    BLOCK_VALID;
    logic                    BLOCK_LAST;
    logic                    BLOCK_READY;

    modport master (
        output IN_BYTE, IN_VALID, IN_KEEP, IN_LAST, BLOCK_READY,
        input  IN_READY, BLOCK_OUT, BLOCK_VALID, BLOCK_LAST
    );

    modport slave (
        input  IN_BYTE, IN_VALID, IN_KEEP, IN_LAST, BLOCK_READY,
        output IN_READY, BLOCK_OUT, BLOCK_VALID, BLOCK_LAST
    );
endinterface

// File: rtl/sha3_pad_absorb_buffer.sv
// Packs a byte stream into SHA-3 rate blocks, applying the 0x06 ... 0x80 padding on the final block,
// and hands each block to the permutation stage over a valid/ready handshake.
module sha3_pad_absorb_buffer #(
    parameter int R_BLOCK_SIZE = 1152
) (
    input  logic                     CLK,
    input  logic                     A_RST,
    sha3_pad_absorb_buffer_if.slave  bus
);
    localparam int               RB         = R_BLOCK_SIZE / 8;
    localparam int               CNT_W      = (RB > 1) ? $clog2(RB) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(RB - 1);
    localparam logic [7:0]       DOMAIN_PAD = 8'h06;
    localparam logic [7:0]       FINAL_PAD  = 8'h80;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RB-1:0][7:0] blk_q, blk_d;
    logic               pad_pending_q, pad_pending_d;
    logic               last_q, last_d;
    logic               in_ready;
    logic               accept;
    logic [CNT_W-1:0]   next_slot;
    logic [R_BLOCK_SIZE-1:0] block_bits;

    // Ready is gated by the reset input so nothing is taken while reset is held.
    assign in_ready  = (state_q == FILL) && !A_RST;
    assign accept    = bus.IN_VALID && in_ready;
    assign next_slot = cnt_q + 1'b1;

    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            blk_q         <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            blk_q         <= blk_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        blk_d         = blk_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (bus.IN_KEEP) begin
                        blk_d[cnt_q] = bus.IN_BYTE;
                        if (cnt_q == LAST_SLOT) begin
                            // A last byte that fills the block leaves no room: padding goes to an extra block.
                            state_d       = EMIT;
                            last_d        = 1'b0;
                            pad_pending_d = bus.IN_LAST;
                        end else if (bus.IN_LAST) begin
                            blk_d[next_slot] = blk_d[next_slot] ^ DOMAIN_PAD;
                            blk_d[LAST_SLOT] = blk_d[LAST_SLOT] ^ FINAL_PAD;
                            state_d          = EMIT;
                            last_d           = 1'b1;
                        end else begin
                            cnt_d = next_slot;
                        end
                    end else if (bus.IN_LAST) begin
                        blk_d[cnt_q]     = blk_d[cnt_q] ^ DOMAIN_PAD;
                        blk_d[LAST_SLOT] = blk_d[LAST_SLOT] ^ FINAL_PAD;
                        state_d          = EMIT;
                        last_d           = 1'b1;
                    end
                end
            end

            EMIT: begin
                if (bus.BLOCK_READY) begin
                    blk_d = '0;
                    cnt_d = '0;
                    if (pad_pending_q) begin
                        blk_d[0]         = DOMAIN_PAD;
                        blk_d[LAST_SLOT] = FINAL_PAD;
                        pad_pending_d    = 1'b0;
                        last_d           = 1'b1;
                    end else begin
                        state_d = FILL;
                        last_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Byte k sits at bits [8k:8k+7] with its MSB at the lowest index.
    always_comb begin
        block_bits = '0;
        for (int k = 0; k < RB; k++) begin
            for (int j = 0; j < 8; j++) begin
                block_bits[8*k + j] = blk_q[k][7-j];
            end
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.BLOCK_OUT   = block_bits;
    assign bus.BLOCK_VALID = (state_q == EMIT);
    assign bus.BLOCK_LAST  = last_q;
endmodule

// File: tb/tb_sha3_pad_absorb_buffer.sv
// Randomised bench for the SHA-3 pad/absorb buffer: a message-level padding model predicts every block.
module tb_sha3_pad_absorb_buffer;
    localparam int R_BLOCK_SIZE = 1152;
    localparam int RB           = R_BLOCK_SIZE / 8;
    localparam int W            = R_BLOCK_SIZE;

    logic CLK = 1'b0;
    logic A_RST;

    always #5 CLK = ~CLK;

    sha3_pad_absorb_buffer_if #(.R_BLOCK_SIZE(R_BLOCK_SIZE)) bus ();

    sha3_pad_absorb_buffer #(.R_BLOCK_SIZE(R_BLOCK_SIZE)) dut (
        .CLK   (CLK),
        .A_RST (A_RST),
        .bus   (bus)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_blocks[$];
    bit           exp_last[$];

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        int w;
        w = 0;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            for (int i = W/32 - 1; i >= 0; i--) begin
                if (got[32*i +: 32] !== exp[32*i +: 32]) w = i;
            end
            $display("[TB] FAIL %s: got %h expected %h (word %0d)", tag, got[32*w +: 32], exp[32*w +: 32], w);
        end
    endtask

    // Padded message = msg, then 0x06, zeros, and 0x80 XORed into the very last byte of the last block.
    function automatic void build_expected(input byte unsigned msg[$]);
        byte unsigned padded[$];
        logic [W-1:0] v;
        int           nblk;
        nblk   = msg.size() / RB + 1;
        padded = msg;
        while (padded.size() < nblk * RB) padded.push_back(8'h00);
        padded[msg.size()]  = padded[msg.size()] ^ 8'h06;
        padded[nblk*RB - 1] = padded[nblk*RB - 1] ^ 8'h80;
        for (int b = 0; b < nblk; b++) begin
            v = '0;
            for (int k = 0; k < RB; k++) begin
                for (int i = 0; i < 8; i++) begin
                    v[8*k + 7 - i] = padded[b*RB + k][i];
                end
            end
            exp_blocks.push_back(v);
            exp_last.push_back(b == nblk - 1);
        end
    endfunction

    task automatic applyStimulus(input byte unsigned msg[$], input bit use_marker);
        int nbeats;
        int in_blk;
        int guard;
        bit keep;
        bit last;
        bit done_blk;
        nbeats = msg.size() + (use_marker ? 1 : 0);
        in_blk = 0;
        for (int i = 0; i < nbeats; i++) begin
            keep = (i < msg.size());
            last = (i == nbeats - 1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                bus.IN_VALID = 1'b1;
                bus.IN_KEEP  = 1'b0;
                bus.IN_LAST  = 1'b0;
                bus.IN_BYTE  = 8'($urandom);
            end
            guard = 0;
            do begin
                @(negedge CLK);
                bus.IN_VALID = 1'b1;
                bus.IN_KEEP  = keep;
                bus.IN_LAST  = last;
                bus.IN_BYTE  = keep ? msg[i] : 8'($urandom);
                guard++;
            end while (!bus.IN_READY && guard < 5000);
            if (!bus.IN_READY) begin
                checkOutput("in_ready_timeout", W'(bus.IN_READY), W'(1));
                bus.IN_VALID = 1'b0;
                return;
            end
            done_blk = last || (keep && in_blk == RB - 1);
            in_blk   = done_blk ? 0 : in_blk + (keep ? 1 : 0);
            if (done_blk) begin
                @(negedge CLK);
                bus.IN_VALID = 1'b0;
                checkOutput("valid_latency", W'(bus.BLOCK_VALID), W'(1));
            end
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic collect_blocks(input int stall);
        int           cycles;
        int           waited;
        bit           held;
        logic [W-1:0] held_out;
        logic         held_last;
        cycles = 0;
        waited = 0;
        held   = 1'b0;
        while (exp_blocks.size() > 0) begin
            @(negedge CLK);
            cycles++;
            if (cycles > 20000) begin
                checkOutput("block_timeout", W'(exp_blocks.size()), W'(0));
                exp_blocks.delete();
                exp_last.delete();
                bus.BLOCK_READY = 1'b0;
                return;
            end
            if (held) begin
                checkOutput("stall_valid", W'(bus.BLOCK_VALID), W'(1));
                checkOutput("stall_out", bus.BLOCK_OUT, held_out);
                checkOutput("stall_last", W'(bus.BLOCK_LAST), W'(held_last));
            end
            if (bus.BLOCK_VALID) begin
                checkOutput("in_ready_blocked", W'(bus.IN_READY), W'(0));
                if (stall > 0) bus.BLOCK_READY = (waited >= stall);
                else           bus.BLOCK_READY = ($urandom_range(0, 2) != 0);
                if (bus.BLOCK_READY) begin
                    checkOutput("block_out", bus.BLOCK_OUT, exp_blocks.pop_front());
                    checkOutput("block_last", W'(bus.BLOCK_LAST), W'(exp_last.pop_front()));
                    held   = 1'b0;
                    waited = 0;
                end else begin
                    held      = 1'b1;
                    held_out  = bus.BLOCK_OUT;
                    held_last = bus.BLOCK_LAST;
                    waited++;
                end
            end else begin
                bus.BLOCK_READY = 1'($urandom_range(0, 1));
                held            = 1'b0;
            end
        end
        @(negedge CLK);
        bus.BLOCK_READY = 1'b0;
    endtask

    task automatic run_message(input byte unsigned msg[$], input bit use_marker, input int stall);
        build_expected(msg);
        fork
            applyStimulus(msg, use_marker);
            collect_blocks(stall);
        join
        @(negedge CLK);
        checkOutput("idle_in_ready", W'(bus.IN_READY), W'(1));
        checkOutput("idle_valid", W'(bus.BLOCK_VALID), W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_in_ready"}, W'(bus.IN_READY), W'(0));
        checkOutput({tag, "_valid"}, W'(bus.BLOCK_VALID), W'(0));
        checkOutput({tag, "_last"}, W'(bus.BLOCK_LAST), W'(0));
        checkOutput({tag, "_out"}, bus.BLOCK_OUT, W'(0));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte unsigned msg[$];
        int           lens[9];
        int           len;
        bit           marker;

        lens = '{0, 1, 142, 143, 144, 145, 287, 288, 289};
        bus.IN_VALID    = 1'b0;
        bus.IN_KEEP     = 1'b0;
        bus.IN_LAST     = 1'b0;
        bus.IN_BYTE     = 8'h00;
        bus.BLOCK_READY = 1'b0;
        A_RST           = 1'b1;

        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        A_RST = 1'b0;
        @(negedge CLK);
        checkOutput("post_reset_ready", W'(bus.IN_READY), W'(1));

        $display("[TB] empty message");
        msg = {};
        run_message(msg, 1'b1, 0);

        $display("[TB] abc");
        msg = {8'h61, 8'h62, 8'h63};
        run_message(msg, 1'b0, 0);

        $display("[TB] 143 bytes of 0xAA");
        msg = {};
        repeat (143) msg.push_back(8'hAA);
        run_message(msg, 1'b0, 0);

        $display("[TB] 144-byte message");
        msg = {};
        repeat (144) msg.push_back(8'($urandom));
        run_message(msg, 1'b0, 0);

        $display("[TB] 300-byte message with 5-cycle stalls");
        msg = {};
        repeat (300) msg.push_back(8'($urandom));
        run_message(msg, 1'b0, 5);

        // Reset in the middle of a partially filled block, asserted away from any clock edge.
        $display("[TB] reset mid-fill");
        bus.BLOCK_READY = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            bus.IN_VALID = 1'b1;
            bus.IN_KEEP  = 1'b1;
            bus.IN_LAST  = 1'b0;
            bus.IN_BYTE  = 8'($urandom_range(1, 255));
            checkOutput("fill_ready", W'(bus.IN_READY), W'(1));
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        #2 A_RST = 1'b1;
        #1 check_reset_outputs("mid_fill_reset");
        @(negedge CLK);
        check_reset_outputs("mid_fill_reset_held");
        A_RST = 1'b0;
        msg = {8'h61, 8'h62, 8'h63};
        run_message(msg, 1'b0, 0);

        $display("[TB] reset while a block is pending");
        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.IN_KEEP  = 1'b1;
        bus.IN_LAST  = 1'b1;
        bus.IN_BYTE  = 8'h5A;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        checkOutput("pending_valid", W'(bus.BLOCK_VALID), W'(1));
        #2 A_RST = 1'b1;
        #1 check_reset_outputs("mid_emit_reset");
        @(negedge CLK);
        A_RST = 1'b0;
        @(negedge CLK);
        checkOutput("after_emit_reset_ready", W'(bus.IN_READY), W'(1));
        checkOutput("after_emit_reset_valid", W'(bus.BLOCK_VALID), W'(0));

        $display("[TB] randomized messages");
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 1) == 0) len = lens[$urandom_range(0, 8)];
            else                           len = $urandom_range(0, 450);
            marker = (len == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            msg = {};
            repeat (len) msg.push_back(8'($urandom));
            run_message(msg, marker, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha3_pad_absorb_buffer.md
Name: sha3_pad_absorb_buffer

Overview:
Upstream neighbour of the permutation stage. It accepts the message as a byte stream with a valid/ready handshake and packs the bytes into R_BLOCK_SIZE-bit rate blocks. On the final block it applies SHA-3 padding (domain byte 0x06, final 0x80). Each block is presented with a valid/ready handshake; BLOCK_VALID drives the permutation's new-message-valid input.

Parameters:
R_BLOCK_SIZE, 1152, rate in bits; multiple of 8; RB = R_BLOCK_SIZE/8 bytes per block (144 by default).

Ports:
CLK  in  1  clock, rising edge.
A_RST  in  1  reset, asynchronous, active-high.
IN_BYTE  in  8  message byte.
IN_VALID  in  1  IN_BYTE/IN_LAST/IN_KEEP valid.
IN_KEEP  in  1  1 = IN_BYTE is data; 0 = no data byte (legal only with IN_LAST=1; used for empty message or end marker).
IN_LAST  in  1  this beat ends the message.
IN_READY  out  1  block accepts a beat.
BLOCK_OUT  out  R_BLOCK_SIZE  packed block, bit index 0 first; byte k occupies [8k:8k+7], byte bit 7 at index 8k.
BLOCK_VALID  out  1  BLOCK_OUT valid.
BLOCK_LAST  out  1  BLOCK_OUT is the final (padded) block of the message.
BLOCK_READY  in  1  downstream takes the block.

Behaviour:
- Reset (A_RST=1, async): state FILL, byte counter cnt=0, buffer all zero, pad_pending=0. IN_READY=0 while reset is asserted. BLOCK_VALID=0, BLOCK_LAST=0, BLOCK_OUT=0.
- Beat accepted when IN_VALID && IN_READY. IN_READY=1 only in FILL (after reset released).
- FILL, accepted beat with IN_KEEP=1: byte written to buffer slot cnt.
  - not last, cnt<RB-1: cnt++.
  - not last, cnt==RB-1: go EMIT, BLOCK_LAST=0.
  - last, cnt<RB-1: XOR 0x06 into slot cnt+1 and 0x80 into slot RB-1; go EMIT, BLOCK_LAST=1. If cnt+1==RB-1, the slot holds 0x86.
  - last, cnt==RB-1: go EMIT, BLOCK_LAST=0, set pad_pending=1.
- FILL, accepted beat with IN_KEEP=0, IN_LAST=1: XOR 0x06 into slot cnt and 0x80 into slot RB-1 (0x86 if cnt==RB-1); go EMIT, BLOCK_LAST=1.
- IN_KEEP=0 with IN_LAST=0 is illegal; the beat is accepted and ignored (no state change).
- EMIT: BLOCK_VALID=1; BLOCK_OUT and BLOCK_LAST are held stable until BLOCK_READY=1. On the handshake cycle:
  - buffer is cleared and cnt=0.
  - if pad_pending: next buffer is 0x06 in slot 0 and 0x80 in slot RB-1; pad_pending cleared; stay in EMIT with BLOCK_LAST=1.
  - else: return to FILL.
- Latency: BLOCK_VALID rises the cycle after the beat that completes the block. Between blocks, IN_READY is low for at least one cycle (the handshake cycle).
- Throughput: at most 1 byte/cycle. No input is accepted while a block is pending, so there is full backpressure.
- Unused buffer bytes are 0. Padding bytes are placed only by the rules above.
- Reset mid-fill or mid-emit: the partial message is discarded and the block returns to reset state immediately.
- BLOCK_VALID never drops without a handshake except on reset.

Test Plan:
- Empty message (one beat: KEEP=0, LAST=1) -> one block: byte0=0x06, bytes 1..142=0x00, byte143=0x80; BLOCK_LAST=1; BLOCK_VALID the next cycle.
- "abc" (0x61, 0x62, 0x63; LAST on 0x63) -> bytes 0..3 = 61 62 63 06, byte143=0x80, rest 0; BLOCK_LAST=1.
- 143-byte message of 0xAA -> single block with bytes 0..142=0xAA, byte143=0x86, BLOCK_LAST=1.
- 144-byte message -> block 1 is all data, BLOCK_LAST=0; after its handshake, block 2 = 06,00..00,80 with BLOCK_LAST=1; IN_READY stays 0 until block 2 is taken.
- 300-byte message with BLOCK_READY held low 5 cycles on each block -> BLOCK_OUT stable while stalled, IN_READY=0; blocks carry 144 + 144 data bytes, then 12 data bytes + 06 + 80 (LAST).
- Assert A_RST after 50 bytes, then send "abc" -> all outputs 0 during reset; output matches the "abc" case with no residue from the first 50 bytes.
